mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the multicycle RISC-V core. Holds the winning requester's transaction on the memory bus until memory answers, then returns the line to that requester with a one-cycle ready pulse. Ties are broken round-robin, so neither cache can starve the other. It sits between the two cache controllers and the memory model, below the `riscv` top.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the icache miss path
// and the dcache miss/writeback path.
//
// A winning request is latched onto the memory bus and held there until memory
// answers with mem_ready. The returned line is captured into the requester's
// rdata register and a one-cycle ready pulse follows. Simultaneous requests are
// resolved round-robin, so neither cache can starve the other.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   i_req/i_addr        - icache line-fill request (held until i_ready)
//   i_ready/i_rdata     - icache completion pulse and fill line
//   d_req/d_we/d_addr   - dcache request: d_we=1 writeback, 0 fill
//   d_wdata             - dcache writeback line
//   d_ready/d_rdata     - dcache completion pulse and fill line
//   mem_req/mem_we      - registered memory transaction strobe and direction
//   mem_addr/mem_wdata  - registered address and write line, stable while granted
//   mem_rdata/mem_ready - memory read line and one-cycle completion pulse
//   busy                - arbiter is not idle
module mem_arbiter #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD,
    StDone
  } state_e;

  // Requester identity, used for both the current owner and the last grant.
  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   busy_q, busy_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic any_req;
  logic pick_d;
  logic granting;
  logic completing;

  // Arbitration: a lone requester wins outright; on a tie the requester that
  // did not win last time goes first.
  always_comb begin
    any_req    = i_req | d_req;
    pick_d     = d_req & (~i_req | (last_grant_q == OwnerI));
    granting   = (state_q == StIdle) & any_req;
    completing = ((state_q == StGrantI) | (state_q == StGrantD)) & mem_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = pick_d ? StGrantD : StGrantI;
          owner_d      = pick_d;
          last_grant_d = pick_d;
        end
      end
      StGrantI, StGrantD: begin
        if (mem_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Always pass through IDLE so a still-high request cannot be re-granted
        // before the requester has seen its ready pulse.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Datapath next-state: bus fields are latched only at grant time, so
  // requester inputs may change freely while the transaction is in flight.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (granting) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pick_d ? d_addr : i_addr;
      mem_we_d   = pick_d & d_we;
      if (pick_d) begin
        mem_wdata_d = d_wdata;
      end
    end
    if (completing) begin
      mem_req_d = 1'b0;
      // Writebacks also capture mem_rdata; the value is simply don't-care.
      if (state_q == StGrantD) begin
        d_rdata_d = mem_rdata;
      end else begin
        i_rdata_d = mem_rdata;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerI;
      last_grant_q <= OwnerI;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs.
  always_comb begin
    i_ready   = (state_q == StDone) & (owner_q == OwnerI);
    d_ready   = (state_q == StDone) & (owner_q == OwnerD);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    busy      = busy_q;
  end

  // Only one requester can ever be completing.
  a_ready_onehot : assert property (@(posedge clk) disable iff (reset) !(i_ready && d_ready));

  // A pending transaction keeps its bus fields until memory answers.
  a_bus_stable : assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_ready) |=> (mem_req && $stable(mem_addr) && $stable(mem_we)
                                 && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned LW = 128;
  localparam int unsigned AW = 32;

  localparam int IDLE = 0;
  localparam int GI   = 1;
  localparam int GD   = 2;
  localparam int DN   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [LW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_ready;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [LW-1:0] wdata;
    int            start;
  } txn_t;

  // Stimulus commands (written by main), expected transactions (written by requesters).
  txn_t iCmds[$];
  txn_t dCmds[$];
  txn_t iExp[$];
  txn_t dExp[$];
  int   iCmdRd = 0, dCmdRd = 0;
  bit   iBusy = 0, dBusy = 0;
  int   abortGen = 0;
  int   memDelay = -1;
  bit   forceStray = 0;

  // Reference model state (written by monitor only).
  int   mState = IDLE, mOwner = 0, mLast = 0;
  int   iExpRd = 0, dExpRd = 0;
  txn_t mTxn;
  int   grantLog[$];
  int   grantCyc[$];
  int   readyCyc[$];

  int nChecks = 0;
  int nFails  = 0;

  function automatic logic [LW-1:0] lineOf(input logic [AW-1:0] a);
    return {32'hDEADBEEF, ~a, a, 32'h0000_0001};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory model: answers each transaction after 0..3 cycles (or memDelay) and
  // sprinkles stray mem_ready pulses while no transaction is on the bus.
  initial begin : memory
    bit started = 0, responded = 0;
    int cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (mem_req) begin
        if (!started) begin
          started = 1;
          cnt = (memDelay >= 0) ? memDelay : int'($urandom_range(0, 3));
        end
        if (!responded) begin
          if (cnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = lineOf(mem_addr);
            responded = 1;
          end else begin
            cnt--;
          end
        end
      end else begin
        started = 0;
        responded = 0;
        if (forceStray || $urandom_range(0, 3) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // icache requester: raises a command, holds it until i_ready, scrambles its
  // address once the model says the grant has been latched.
  initial begin : reqI
    int seen = 0, age = 0;
    bit rdy;
    i_req = 1'b0;
    i_addr = '0;
    forever begin
      @(negedge clk);
      rdy = i_ready;
      @(posedge clk);
      #1;
      if (abortGen != seen) begin
        seen = abortGen;
        i_req = 1'b0;
        iBusy = 0;
      end else if (iBusy) begin
        age++;
        if (rdy || age > 200) begin
          i_req = 1'b0;
          iBusy = 0;
        end else if (mState == GI) begin
          i_addr = $urandom;
        end
      end else if (iCmdRd < iCmds.size() && cyc >= iCmds[iCmdRd].start) begin
        i_addr = iCmds[iCmdRd].addr;
        i_req = 1'b1;
        iExp.push_back(iCmds[iCmdRd]);
        iCmdRd++;
        iBusy = 1;
        age = 0;
      end else begin
        i_addr = $urandom;
      end
    end
  end

  // dcache requester.
  initial begin : reqD
    int seen = 0, age = 0;
    bit rdy;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    forever begin
      @(negedge clk);
      rdy = d_ready;
      @(posedge clk);
      #1;
      if (abortGen != seen) begin
        seen = abortGen;
        d_req = 1'b0;
        dBusy = 0;
      end else if (dBusy) begin
        age++;
        if (rdy || age > 200) begin
          d_req = 1'b0;
          dBusy = 0;
        end else if (mState == GD) begin
          d_addr = $urandom;
          d_we = 1'($urandom);
          d_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (dCmdRd < dCmds.size() && cyc >= dCmds[dCmdRd].start) begin
        d_addr = dCmds[dCmdRd].addr;
        d_we = dCmds[dCmdRd].we;
        d_wdata = dCmds[dCmdRd].wdata;
        d_req = 1'b1;
        dExp.push_back(dCmds[dCmdRd]);
        dCmdRd++;
        dBusy = 1;
        age = 0;
      end else begin
        d_addr = $urandom;
        d_we = 1'($urandom);
      end
    end
  end

  // Monitor: advances the transaction-level model by one cycle from the inputs
  // seen last cycle, then compares every DUT output against it.
  initial begin : monitor
    bit pI = 0, pD = 0, pMr = 0, pRst = 0, armed = 0, have;
    logic [LW-1:0] pMrd = '0, expIr = '0, expDr = '0;
    forever begin
      @(negedge clk);
      if (pRst) begin
        armed = 1;
        mState = IDLE;
        mLast = 0;
        mOwner = 0;
        expIr = '0;
        expDr = '0;
        iExpRd = iExp.size();
        dExpRd = dExp.size();
      end else begin
        case (mState)
          IDLE: begin
            if (pI || pD) begin
              mOwner = (pI && pD) ? 1 - mLast : (pD ? 1 : 0);
              mLast = mOwner;
              mState = (mOwner == 1) ? GD : GI;
              have = (mOwner == 1) ? (dExpRd < dExp.size()) : (iExpRd < iExp.size());
              if (armed) chk("grant has pending txn", have, 1);
              if (have) mTxn = (mOwner == 1) ? dExp[dExpRd] : iExp[iExpRd];
              grantLog.push_back(mOwner);
              grantCyc.push_back(cyc);
            end
          end
          GI, GD: begin
            if (pMr) begin
              mState = DN;
              if (mOwner == 1) begin
                expDr = pMrd;
                dExpRd++;
              end else begin
                expIr = pMrd;
                iExpRd++;
              end
              readyCyc.push_back(cyc);
            end
          end
          default: mState = IDLE;
        endcase
      end
      if (armed) begin
        chk("mem_req", mem_req, (mState == GI || mState == GD));
        chk("busy", busy, (mState != IDLE));
        chk("i_ready", i_ready, (mState == DN && mOwner == 0));
        chk("d_ready", d_ready, (mState == DN && mOwner == 1));
        chk("i_rdata", i_rdata, expIr);
        chk("d_rdata", d_rdata, expDr);
        if (mState == GI || mState == GD) begin
          chk("mem_addr", mem_addr, mTxn.addr);
          chk("mem_we", mem_we, (mState == GD) && mTxn.we);
          if (mState == GD && mTxn.we) chk("mem_wdata", mem_wdata, mTxn.wdata);
        end
        if (mState == DN && !mTxn.we) begin
          if (mOwner == 1) chk("d fill line", d_rdata, lineOf(mTxn.addr));
          else chk("i fill line", i_rdata, lineOf(mTxn.addr));
        end
        if (pRst) begin
          chk("reset mem_addr", mem_addr, 0);
          chk("reset mem_we", mem_we, 0);
          chk("reset mem_wdata", mem_wdata, 0);
        end
      end
      pI = i_req;
      pD = d_req;
      pMr = mem_ready;
      pMrd = mem_rdata;
      pRst = reset;
    end
  end

  task automatic pushI(input logic [AW-1:0] a, input int start);
    txn_t t;
    t.addr = a;
    t.we = 1'b0;
    t.wdata = '0;
    t.start = start;
    iCmds.push_back(t);
  endtask

  task automatic pushD(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] w,
                       input int start);
    txn_t t;
    t.addr = a;
    t.we = we;
    t.wdata = w;
    t.start = start;
    dCmds.push_back(t);
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (iCmdRd == iCmds.size() && dCmdRd == dCmds.size() && !iBusy && !dBusy
          && mState == IDLE) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s, n, nr, it, dt;
    int tieExp[4];
    bit ok;
    tieExp[0] = 1;
    tieExp[1] = 0;
    tieExp[2] = 1;
    tieExp[3] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Two ties after reset: expect D, I, D, I.
    s = cyc + 2;
    pushI(32'h0000_1000, s);
    pushD(32'h0000_2000, 1'b0, '0, s);
    drain("drain tie 1");
    s = cyc + 2;
    pushI(32'h0000_3000, s);
    pushD(32'h0000_4000, 1'b0, '0, s);
    drain("drain tie 2");
    chk("tie grant count", grantLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grantLog.size()) chk("tie grant order", grantLog[i], tieExp[i]);
    end

    // Single icache fill, memory answers on the third grant cycle.
    memDelay = 2;
    pushI(32'h0000_0040, cyc + 1);
    drain("drain single fill");
    n = grantLog.size();
    chk("fill owner", grantLog[n-1], 0);
    chk("fill grant-to-ready", readyCyc[n-1] - grantCyc[n-1], 3);

    // Dcache writeback.
    memDelay = 1;
    pushD(32'h0000_0100, 1'b1, {16{8'hA5}}, cyc + 1);
    drain("drain writeback");
    n = grantLog.size();
    chk("writeback owner", grantLog[n-1], 1);

    // Back-to-back: icache request arrives while D holds the bus.
    memDelay = 3;
    s = cyc + 1;
    pushD(32'h0000_0200, 1'b0, '0, s);
    pushI(32'h0000_0300, s + 2);
    drain("drain back-to-back");
    n = grantLog.size();
    chk("b2b first owner", grantLog[n-2], 1);
    chk("b2b second owner", grantLog[n-1], 0);
    chk("b2b mem_req gap", grantCyc[n-1] - readyCyc[n-2], 2);

    // Random traffic with scrambled inputs and stray mem_ready pulses.
    memDelay = -1;
    s = cyc + 1;
    it = 0;
    dt = 0;
    for (int k = 0; k < 60; k++) begin
      it += $urandom_range(0, 6);
      dt += $urandom_range(0, 6);
      pushI($urandom, s + it);
      pushD($urandom, 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, s + dt);
    end
    drain("drain random");
    chk("random grants all completed", grantLog.size(), readyCyc.size());

    // Reset while a dcache writeback holds the bus.
    memDelay = 6;
    pushD(32'h0000_0500, 1'b1, {4{32'h1234_5678}}, cyc + 1);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (mState == GD) begin
        ok = 1;
        break;
      end
    end
    chk("reached GRANT_D", ok, 1);
    nr = readyCyc.size();
    @(posedge clk);
    #1;
    reset = 1'b1;
    abortGen++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    forceStray = 1;
    repeat (3) @(posedge clk);
    #1;
    forceStray = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("no ready after reset", readyCyc.size(), nr);
    chk("idle after reset", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
